// File: rtl/l2_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : l2_arbiter
// Purpose  : Round-robin arbiter sharing one L2 port between L1 I- and D-cache.
// Revision : 1.0 - initial release
// ============================================================================
module l2_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_mem_read,
  input  logic [ADDR_WIDTH-1:0] i_mem_address,
  output logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  i_mem_resp,
  input  logic                  d_mem_read,
  input  logic                  d_mem_write,
  input  logic [ADDR_WIDTH-1:0] d_mem_address,
  input  logic [DATA_WIDTH-1:0] d_mem_wdata,
  output logic [DATA_WIDTH-1:0] d_mem_rdata,
  output logic                  d_mem_resp,
  output logic                  l2_read,
  output logic                  l2_write,
  output logic [ADDR_WIDTH-1:0] l2_address,
  output logic [DATA_WIDTH-1:0] l2_wdata,
  input  logic [DATA_WIDTH-1:0] l2_rdata,
  input  logic                  l2_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_last_d;
  logic                  w_last_d_next;
  logic                  r_op_write;
  logic                  w_op_write_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] w_addr_next;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] w_wdata_next;

  logic w_req_i;
  logic w_req_d;

  assign w_req_i = i_mem_read;
  assign w_req_d = d_mem_read | d_mem_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_last_d   <= 1'b0;
      r_op_write <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_last_d   <= w_last_d_next;
      r_op_write <= w_op_write_next;
      r_addr     <= w_addr_next;
      r_wdata    <= w_wdata_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_last_d_next   = r_last_d;
    w_op_write_next = r_op_write;
    w_addr_next     = r_addr;
    w_wdata_next    = r_wdata;
    case (r_state)
      IDLE: begin
        // On a tie, D wins unless it was the side granted last.
        if (w_req_d && (!w_req_i || !r_last_d)) begin
          w_state_next    = SERVE_D;
          w_last_d_next   = 1'b1;
          w_op_write_next = d_mem_write;
          w_addr_next     = d_mem_address;
          w_wdata_next    = d_mem_wdata;
        end else if (w_req_i) begin
          w_state_next    = SERVE_I;
          w_last_d_next   = 1'b0;
          w_op_write_next = 1'b0;
          w_addr_next     = i_mem_address;
        end
      end
      SERVE_I, SERVE_D: begin
        if (l2_resp) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // L2-side outputs depend only on registered state, never on requester inputs.
  assign l2_read     = (r_state != IDLE) && !r_op_write;
  assign l2_write    = (r_state != IDLE) &&  r_op_write;
  assign l2_address  = r_addr;
  assign l2_wdata    = r_wdata;

  assign i_mem_resp  = (r_state == SERVE_I) && l2_resp;
  assign d_mem_resp  = (r_state == SERVE_D) && l2_resp;
  assign i_mem_rdata = l2_rdata;
  assign d_mem_rdata = l2_rdata;

endmodule
`default_nettype wire

// File: tb/tb_l2_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_l2_arbiter
// Purpose  : Directed self-checking bench for l2_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l2_arbiter;

  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 128;

  logic                  clk;
  logic                  reset;
  logic                  i_mem_read;
  logic [ADDR_WIDTH-1:0] i_mem_address;
  logic [DATA_WIDTH-1:0] i_mem_rdata;
  logic                  i_mem_resp;
  logic                  d_mem_read;
  logic                  d_mem_write;
  logic [ADDR_WIDTH-1:0] d_mem_address;
  logic [DATA_WIDTH-1:0] d_mem_wdata;
  logic [DATA_WIDTH-1:0] d_mem_rdata;
  logic                  d_mem_resp;
  logic                  l2_read;
  logic                  l2_write;
  logic [ADDR_WIDTH-1:0] l2_address;
  logic [DATA_WIDTH-1:0] l2_wdata;
  logic [DATA_WIDTH-1:0] l2_rdata;
  logic                  l2_resp;

  int n_assert = 0;
  int n_fail   = 0;

  l2_arbiter #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_mem_read   (i_mem_read),
    .i_mem_address(i_mem_address),
    .i_mem_rdata  (i_mem_rdata),
    .i_mem_resp   (i_mem_resp),
    .d_mem_read   (d_mem_read),
    .d_mem_write  (d_mem_write),
    .d_mem_address(d_mem_address),
    .d_mem_wdata  (d_mem_wdata),
    .d_mem_rdata  (d_mem_rdata),
    .d_mem_resp   (d_mem_resp),
    .l2_read      (l2_read),
    .l2_write     (l2_write),
    .l2_address   (l2_address),
    .l2_wdata     (l2_wdata),
    .l2_rdata     (l2_rdata),
    .l2_resp      (l2_resp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [DATA_WIDTH-1:0] obs,
                     input logic [DATA_WIDTH-1:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks strobes, address and both resp outputs in one call.
  task automatic chk_bus(input string tag, input logic rd, input logic wr,
                         input logic [ADDR_WIDTH-1:0] addr, input logic ir,
                         input logic dr);
    chk({tag, ".l2_read"},    l2_read,    rd);
    chk({tag, ".l2_write"},   l2_write,   wr);
    chk({tag, ".l2_address"}, l2_address, addr);
    chk({tag, ".i_mem_resp"}, i_mem_resp, ir);
    chk({tag, ".d_mem_resp"}, d_mem_resp, dr);
  endtask

  logic [DATA_WIDTH-1:0] c_wdata;
  logic [DATA_WIDTH-1:0] c_rdata_a;
  logic [DATA_WIDTH-1:0] c_rdata_b;

  initial begin
    c_wdata   = 128'h0123456789ABCDEF0123456789ABCDEF;
    c_rdata_a = {8{16'hAAAA}};
    c_rdata_b = {8{16'h5A5A}};

    reset = 1'b1;
    i_mem_read = 1'b0; i_mem_address = '0;
    d_mem_read = 1'b0; d_mem_write = 1'b0; d_mem_address = '0; d_mem_wdata = '0;
    l2_rdata = '0; l2_resp = 1'b0;

    // Reset state
    @(negedge clk); @(negedge clk);
    #1;
    chk_bus("reset", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk("reset.l2_wdata", l2_wdata, '0);
    reset = 1'b0;

    // Single I read
    @(negedge clk);
    i_mem_read = 1'b1; i_mem_address = 16'h1230;
    @(negedge clk); #1;
    chk_bus("iread.c1", 1'b1, 1'b0, 16'h1230, 1'b0, 1'b0);
    @(negedge clk); #1;
    chk_bus("iread.c2", 1'b1, 1'b0, 16'h1230, 1'b0, 1'b0);
    @(negedge clk);
    l2_resp = 1'b1; l2_rdata = c_rdata_a; i_mem_read = 1'b0; #1;
    chk_bus("iread.resp", 1'b1, 1'b0, 16'h1230, 1'b1, 1'b0);
    chk("iread.rdata", i_mem_rdata, c_rdata_a);
    @(negedge clk);
    l2_resp = 1'b0; #1;
    chk_bus("iread.idle", 1'b0, 1'b0, 16'h1230, 1'b0, 1'b0);

    // D writeback
    @(negedge clk);
    d_mem_write = 1'b1; d_mem_address = 16'h4560; d_mem_wdata = c_wdata;
    @(negedge clk); #1;
    chk_bus("dwb.c1", 1'b0, 1'b1, 16'h4560, 1'b0, 1'b0);
    chk("dwb.wdata", l2_wdata, c_wdata);
    @(negedge clk);
    l2_resp = 1'b1; d_mem_write = 1'b0; #1;
    chk_bus("dwb.resp", 1'b0, 1'b1, 16'h4560, 1'b0, 1'b1);
    @(negedge clk);
    l2_resp = 1'b0; #1;
    chk_bus("dwb.idle", 1'b0, 1'b0, 16'h4560, 1'b0, 1'b0);

    // Simultaneous requests straight out of reset: D first, then I
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    i_mem_read = 1'b1; i_mem_address = 16'h0010;
    d_mem_read = 1'b1; d_mem_address = 16'h0020;
    @(negedge clk); #1;
    chk_bus("tie.d", 1'b1, 1'b0, 16'h0020, 1'b0, 1'b0);
    @(negedge clk);
    l2_resp = 1'b1; l2_rdata = c_rdata_b; d_mem_read = 1'b0; #1;
    chk_bus("tie.dresp", 1'b1, 1'b0, 16'h0020, 1'b0, 1'b1);
    chk("tie.drdata", d_mem_rdata, c_rdata_b);
    @(negedge clk);
    l2_resp = 1'b0; #1;
    chk_bus("tie.gap", 1'b0, 1'b0, 16'h0020, 1'b0, 1'b0);
    @(negedge clk); #1;
    chk_bus("tie.i", 1'b1, 1'b0, 16'h0010, 1'b0, 1'b0);
    @(negedge clk);
    l2_resp = 1'b1; i_mem_read = 1'b0; #1;
    chk_bus("tie.iresp", 1'b1, 1'b0, 16'h0010, 1'b1, 1'b0);
    @(negedge clk);
    l2_resp = 1'b0; #1;
    chk_bus("tie.idle", 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0);

    // Sustained contention: last grant was I, so order is D,I,D,I,D,I
    @(negedge clk);
    i_mem_read = 1'b1; i_mem_address = 16'h1000;
    d_mem_read = 1'b1; d_mem_address = 16'h2000;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      l2_resp = 1'b1; #1;
      if (t % 2 == 0)
        chk_bus($sformatf("rr%0d.d", t), 1'b1, 1'b0, 16'h2000, 1'b0, 1'b1);
      else
        chk_bus($sformatf("rr%0d.i", t), 1'b1, 1'b0, 16'h1000, 1'b1, 1'b0);
      @(negedge clk);
      l2_resp = 1'b0;
      if (t == 5) begin
        i_mem_read = 1'b0; d_mem_read = 1'b0;
      end
      #1;
      chk_bus($sformatf("rr%0d.gap", t), 1'b0, 1'b0,
              (t % 2 == 0) ? 16'h2000 : 16'h1000, 1'b0, 1'b0);
    end

    // Read and write together: write wins
    @(negedge clk);
    d_mem_read = 1'b1; d_mem_write = 1'b1; d_mem_address = 16'h7770;
    d_mem_wdata = ~c_wdata;
    @(negedge clk); #1;
    chk_bus("rw.c1", 1'b0, 1'b1, 16'h7770, 1'b0, 1'b0);
    chk("rw.wdata", l2_wdata, ~c_wdata);
    @(negedge clk);
    l2_resp = 1'b1; d_mem_read = 1'b0; d_mem_write = 1'b0; #1;
    chk_bus("rw.resp", 1'b0, 1'b1, 16'h7770, 1'b0, 1'b1);
    @(negedge clk);
    l2_resp = 1'b0;

    // Reset in SERVE_I before l2_resp
    @(negedge clk);
    i_mem_read = 1'b1; i_mem_address = 16'h3330;
    @(negedge clk); #1;
    chk_bus("rst.serve", 1'b1, 1'b0, 16'h3330, 1'b0, 1'b0);
    #2;
    reset = 1'b1; i_mem_read = 1'b0; #1;
    chk_bus("rst.async", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    l2_resp = 1'b1; #1;
    chk_bus("rst.stray", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    l2_resp = 1'b0; #1;
    chk_bus("rst.after", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
